// File: rtl/i_fetch_buf_pkg.sv
// i_fetch_buf_pkg: default widths, branch opcode and fetch FSM state type shared by the fetch unit
package i_fetch_buf_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;
  localparam int DEF_QDEPTH = 4;
  localparam int DEF_VLEN = 128;
  localparam int DEF_SB_POS_W = 4;
  localparam int DEF_REG_W = 5;
  localparam int DEF_ALU_ENTRY_SIZE = 8;
  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, STALL, DRAIN} fetch_state_e;
endpackage

// File: rtl/i_fetch_buf_inst_queue.sv
// inst_queue: synchronous FIFO holding fetched {inst, pc} entries
//   clk, rst_n      : clock, async active-low reset (clears pointers and storage)
//   push/din        : enqueue din
//   pop             : dequeue head (ignored when empty)
//   clear           : empty the queue
//   head            : entry at the read pointer
//   full/empty/count: occupancy status
module inst_queue #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign count = wr - rd;
  assign do_pop = pop && !empty;
  // a pop frees the slot the same-cycle push lands in
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) mem[wr[AW-1:0]] <= din;
      wr <= wr + {{AW{1'b0}}, do_push};
      rd <= rd + {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/i_fetch_buf.sv
// i_fetch_buf: sequential instruction fetch into a decoupling queue for decode
//   clk, rst_n             : clock, async active-low reset
//   wb_*                   : writeback bus; resolves a stalled conditional branch
//   flush, flush_pc        : discard queued/in-flight fetches and redirect
//   id_ready/id_valid/id_* : decode handshake on the queue head
//   mc_valid/mc_addr       : one-cycle memory request pulse and its address
//   mc_done/mc_inst        : memory response
//   fetch_stalled          : waiting for branch resolution
module i_fetch_buf
  import i_fetch_buf_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int ILEN = DEF_ILEN,
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int VLEN = DEF_VLEN,
  parameter int SB_POS_W = DEF_SB_POS_W,
  parameter int REG_W = DEF_REG_W,
  parameter int ALU_ENTRY_SIZE = DEF_ALU_ENTRY_SIZE,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  input  logic [SB_POS_W-1:0] wb_pos,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic [VLEN-1:0]     wb_value,
  input  logic                flush,
  input  logic [XLEN-1:0]     flush_pc,
  input  logic                id_ready,
  output logic                id_valid,
  output logic [ILEN-1:0]     id_inst,
  output logic [XLEN-1:0]     id_pc,
  output logic                mc_valid,
  output logic [XLEN-1:0]     mc_addr,
  input  logic                mc_done,
  input  logic [ILEN-1:0]     mc_inst,
  output logic                fetch_stalled
);
  localparam int CW = $clog2(QDEPTH) + 1;
  fetch_state_e state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic mc_valid_n, push, pop, q_full, q_empty, resolve;
  logic [CW-1:0] q_count;
  logic unused;
  assign unused = ^{wb_value[VLEN-1:XLEN], q_full};
  assign id_valid = !q_empty;
  assign pop = id_valid && id_ready;
  assign mc_addr = pc;
  assign fetch_stalled = state == STALL;
  assign resolve = wb_valid && wb_rd == '0 && int'(wb_pos) < ALU_ENTRY_SIZE;
  inst_queue #(.W(ILEN + XLEN), .DEPTH(QDEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .clear(flush),
    .din({mc_inst, pc}),
    .head({id_inst, id_pc}),
    .full(q_full),
    .empty(q_empty),
    .count(q_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      mc_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      mc_valid <= mc_valid_n;
    end
  always_comb begin
    state_n = state;
    pc_n = pc;
    mc_valid_n = 1'b0;
    push = 1'b0;
    if (flush) begin
      pc_n = flush_pc;
      // a request still in flight must be drained before fetching again
      state_n = ((state == WAIT_MEM || state == DRAIN) && !mc_done) ? DRAIN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          // only one request in flight, so a free slot now is still free at response time
          mc_valid_n = q_count < CW'(QDEPTH);
          state_n = mc_valid_n ? WAIT_MEM : IDLE;
        end
        WAIT_MEM: if (mc_done) begin
          push = 1'b1;
          pc_n = pc + XLEN'(4);
          state_n = mc_inst[6:0] == BRANCH_OP ? STALL : IDLE;
        end
        STALL: if (resolve) begin
          // pc already points past the branch; offset is relative to that
          pc_n = pc + wb_value[XLEN-1:0];
          state_n = IDLE;
        end
        DRAIN: state_n = mc_done ? IDLE : DRAIN;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
